// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM delay-line scheduler.
//   SDRAM_ADDR_W : SDRAM word address width
//   state_e      : scheduler FSM states
//   clamp_delay  : limits a requested delay to [1, 2**region_w-1]
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 22;

  typedef enum logic [2:0] {
    StWait,
    StIdle,
    StUpdate,
    StIssue,
    StBusy
  } state_e;

  // A delay of 0 would read the word being written in the same run, so it is raised to 1.
  function automatic logic [31:0] clamp_delay(input logic [31:0] d, input int unsigned region_w);
    logic [31:0] hi;
    hi = (32'd1 << region_w) - 32'd1;
    if (d == '0) return 32'd1;
    if (d > hi) return hi;
    return d;
  endfunction

endpackage

// File: rtl/delay_slew.sv
// Per-channel slew limiter for the effective delay length.
//   clk_i, srst_i : clock, synchronous active-high reset (delay resets to 1)
//   en_i          : step the delay toward the target this clock
//   tgt_i         : requested delay in samples (clamped internally)
//   cur_delay_o   : delay in effect for the current clock (post-step when en_i=1)
module delay_slew
  import sdram_pkg::*;
#(
  parameter int unsigned REGION_W  = 20,
  parameter int unsigned SLEW_STEP = 1
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                en_i,
  input  logic [REGION_W-1:0] tgt_i,
  output logic [REGION_W-1:0] cur_delay_o
);

  localparam logic [REGION_W-1:0] Step = REGION_W'(SLEW_STEP);

  logic [REGION_W-1:0] cur_q, cur_d, tgt, gap;

  always_comb begin
    tgt   = REGION_W'(clamp_delay(32'(tgt_i), REGION_W));
    cur_d = cur_q;
    gap   = '0;
    if (en_i) begin
      if (tgt > cur_q) begin
        gap   = tgt - cur_q;
        cur_d = cur_q + ((gap < Step) ? gap : Step);
      end else begin
        gap   = cur_q - tgt;
        cur_d = cur_q - ((gap < Step) ? gap : Step);
      end
    end
  end

  // The read address of a run uses the already-stepped delay.
  assign cur_delay_o = cur_d;

  always_ff @(posedge clk_i) begin
    if (srst_i) cur_q <= REGION_W'(1);
    else        cur_q <= cur_d;
  end

endmodule

// File: rtl/sdram_delay_scheduler.sv
// Per-sample sequencer for the multi-channel SDRAM delay-line controller.
//   clk_i, srst_i    : SDRAM clock, synchronous active-high reset
//   sample_tick_i    : one-cycle strobe per audio sample
//   delay_i          : requested delay per channel, in samples
//   freeze_i         : per-channel write mask (loop hold)
//   ctrl_ready_i     : controller initialised
//   start_o          : one-cycle start pulse to the controller
//   write_address_o  : per-channel write address {channel, wr_ptr}
//   read_address_o   : per-channel read address {channel, wr_ptr - delay}
//   write_enable_o   : per-channel write enable
//   overrun_o        : pulse when a tick is dropped
//   overrun_cnt_o    : saturating count of dropped ticks
module sdram_delay_scheduler
  import sdram_pkg::*;
#(
  parameter int unsigned NUM         = 4,
  parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
  parameter int unsigned REGION_W    = 20,
  parameter int unsigned SLEW_STEP   = 1,
  parameter int unsigned BUSY_CYCLES = 160
) (
  input  logic                           clk_i,
  input  logic                           srst_i,
  input  logic                           sample_tick_i,
  input  logic [NUM-1:0][REGION_W-1:0]   delay_i,
  input  logic [NUM-1:0]                 freeze_i,
  input  logic                           ctrl_ready_i,
  output logic                           start_o,
  output logic [NUM-1:0][ADDR_W-1:0]     write_address_o,
  output logic [NUM-1:0][ADDR_W-1:0]     read_address_o,
  output logic [NUM-1:0]                 write_enable_o,
  output logic                           overrun_o,
  output logic [15:0]                    overrun_cnt_o
);

  localparam int unsigned CH_W = ADDR_W - REGION_W;
  localparam int unsigned BW   = $clog2(BUSY_CYCLES);
  localparam logic [BW-1:0] BusyLast = BW'(BUSY_CYCLES - 1);

  state_e                       state_q, state_d;
  logic                         pending_q, pending_d;
  logic                         start_q, start_d;
  logic                         ovr_q, ovr_d;
  logic [15:0]                  ovr_cnt_q, ovr_cnt_d;
  logic [BW-1:0]                busy_cnt_q, busy_cnt_d;
  logic [NUM-1:0][REGION_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM-1:0][ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [NUM-1:0]               we_q, we_d;
  logic                         upd;
  logic [REGION_W-1:0]          cur_nxt [NUM];

  for (genvar c = 0; c < NUM; c++) begin : g_ch
    delay_slew #(
      .REGION_W  (REGION_W),
      .SLEW_STEP (SLEW_STEP)
    ) u_slew (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .en_i        (upd),
      .tgt_i       (delay_i[c]),
      .cur_delay_o (cur_nxt[c])
    );
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    start_d    = 1'b0;
    ovr_d      = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;
    busy_cnt_d = busy_cnt_q;
    upd        = 1'b0;

    if (!ctrl_ready_i) begin
      state_d   = StWait;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StWait:   state_d = StIdle;
        StIdle: begin
          if (sample_tick_i || pending_q) begin
            state_d   = StUpdate;
            pending_d = 1'b0;
          end
        end
        StUpdate: begin
          upd     = 1'b1;
          start_d = 1'b1;
          state_d = StIssue;
        end
        StIssue: begin
          busy_cnt_d = '0;
          state_d    = StBusy;
        end
        StBusy: begin
          if (busy_cnt_q == BusyLast) state_d = StIdle;
          else                        busy_cnt_d = busy_cnt_q + BW'(1);
        end
        default:  state_d = StWait;
      endcase

      // Ticks while a run is in flight keep at most one pending run; extras are dropped.
      if (sample_tick_i && (state_q inside {StUpdate, StIssue, StBusy})) begin
        if (!pending_q) begin
          pending_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
          if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    we_d      = we_q;
    if (upd) begin
      for (int c = 0; c < NUM; c++) begin
        wr_addr_d[c] = {CH_W'(c), wr_ptr_q[c]};
        rd_addr_d[c] = {CH_W'(c), wr_ptr_q[c] - cur_nxt[c]};
        we_d[c]      = !freeze_i[c];
        // The pointer advances even when frozen so read timing is unaffected.
        wr_ptr_d[c]  = wr_ptr_q[c] + REGION_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= StWait;
      pending_q  <= 1'b0;
      start_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
      busy_cnt_q <= '0;
      wr_ptr_q   <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      start_q    <= start_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      we_q       <= we_d;
    end
  end

  assign start_o         = start_q;
  assign write_address_o = wr_addr_q;
  assign read_address_o  = rd_addr_q;
  assign write_enable_o  = we_q;
  assign overrun_o       = ovr_q;
  assign overrun_cnt_o   = ovr_cnt_q;

endmodule

// File: tb/tb_sdram_delay_scheduler.sv
// Randomised bench for sdram_delay_scheduler against a time-based reference model.
// A small ring (REGION_W=6) lets the write pointer wrap within the run.
module tb_sdram_delay_scheduler;

  localparam int NUM         = 4;
  localparam int ADDR_W      = 8;
  localparam int REGION_W    = 6;
  localparam int SLEW_STEP   = 1;
  localparam int BUSY_CYCLES = 128;
  localparam int RING        = 1 << REGION_W;

  logic                         clk = 1'b0;
  logic                         srst;
  logic                         tick;
  logic                         ready;
  logic [NUM-1:0][REGION_W-1:0] delay;
  logic [NUM-1:0]               freeze;
  logic                         start_o;
  logic [NUM-1:0][ADDR_W-1:0]   write_address_o;
  logic [NUM-1:0][ADDR_W-1:0]   read_address_o;
  logic [NUM-1:0]               write_enable_o;
  logic                         overrun_o;
  logic [15:0]                  overrun_cnt_o;

  sdram_delay_scheduler #(
    .NUM         (NUM),
    .ADDR_W      (ADDR_W),
    .REGION_W    (REGION_W),
    .SLEW_STEP   (SLEW_STEP),
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .sample_tick_i   (tick),
    .delay_i         (delay),
    .freeze_i        (freeze),
    .ctrl_ready_i    (ready),
    .start_o         (start_o),
    .write_address_o (write_address_o),
    .read_address_o  (read_address_o),
    .write_enable_o  (write_enable_o),
    .overrun_o       (overrun_o),
    .overrun_cnt_o   (overrun_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: a run is scheduled in time; the controller is free again at m_free_at.
  int             cyc_n;
  int             m_ptr [NUM];
  int             m_cur [NUM];
  bit             m_pending, m_online;
  int             m_update_at, m_free_at;
  int             exp_wr [NUM];
  int             exp_rd [NUM];
  logic [NUM-1:0] exp_we;
  logic           exp_start, exp_ovr;
  int             exp_cnt;
  int             n_vec, n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic run_channels();
    for (int c = 0; c < NUM; c++) begin
      int tgt;
      tgt = (delay[c] == 0) ? 1 : int'(delay[c]);
      if (tgt > m_cur[c]) m_cur[c] += ((tgt - m_cur[c]) < SLEW_STEP) ? (tgt - m_cur[c]) : SLEW_STEP;
      else                m_cur[c] -= ((m_cur[c] - tgt) < SLEW_STEP) ? (m_cur[c] - tgt) : SLEW_STEP;
      exp_wr[c] = c * RING + m_ptr[c];
      exp_rd[c] = c * RING + ((m_ptr[c] - m_cur[c] + RING) % RING);
      exp_we[c] = !freeze[c];
      m_ptr[c]  = (m_ptr[c] + 1) % RING;
    end
  endtask

  task automatic model_step();
    exp_start = 1'b0;
    exp_ovr   = 1'b0;
    if (srst) begin
      for (int c = 0; c < NUM; c++) begin
        m_ptr[c] = 0; m_cur[c] = 1; exp_wr[c] = 0; exp_rd[c] = 0;
      end
      exp_we = '0; exp_cnt = 0;
      m_online = 0; m_pending = 0; m_update_at = -1; m_free_at = 0;
    end else if (!ready) begin
      m_online = 0; m_pending = 0; m_update_at = -1;
    end else if (!m_online) begin
      m_online  = 1;
      m_free_at = cyc_n + 1;
    end else begin
      if (cyc_n == m_update_at) begin
        run_channels();
        exp_start = 1'b1;
      end
      if (cyc_n >= m_free_at) begin
        if (tick || m_pending) begin
          m_pending   = 0;
          m_update_at = cyc_n + 1;
          m_free_at   = cyc_n + 3 + BUSY_CYCLES;
        end
      end else if (tick) begin
        if (m_pending) begin
          exp_ovr = 1'b1;
          if (exp_cnt < 65535) exp_cnt++;
        end else begin
          m_pending = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("start_o", 64'(start_o), 64'(exp_start));
    check_eq("overrun_o", 64'(overrun_o), 64'(exp_ovr));
    check_eq("overrun_cnt_o", 64'(overrun_cnt_o), 64'(exp_cnt));
    check_eq("write_enable_o", 64'(write_enable_o), 64'(exp_we));
    for (int c = 0; c < NUM; c++) begin
      check_eq("write_address_o", 64'(write_address_o[c]), 64'(exp_wr[c]));
      check_eq("read_address_o", 64'(read_address_o[c]), 64'(exp_rd[c]));
    end
  endtask

  task automatic step(input logic t, input logic r, input logic s);
    @(negedge clk);
    tick  = t;
    ready = r;
    srst  = s;
    @(posedge clk);
    model_step();
    cyc_n++;
    #1 compare_all();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc_n = 0;
    tick = 1'b0; ready = 1'b0; srst = 1'b1;
    delay = {NUM{6'd40}}; freeze = '0;

    // Reset, then a single tick with a large delay.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("t1_start_latency", 64'(start_o), 64'd1);
    check_eq("t1_wr_ch1", 64'(write_address_o[1]), 64'h40);
    check_eq("t1_rd_ch2_slewed", 64'(read_address_o[2]), 64'hBE);
    repeat (140) step(1'b0, 1'b1, 1'b0);

    // Slew: settle at 1, then step toward 5.
    delay = {NUM{6'd1}};
    step(1'b1, 1'b1, 1'b0);
    repeat (135) step(1'b0, 1'b1, 1'b0);
    delay = {NUM{6'd5}};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (135) step(1'b0, 1'b1, 1'b0);
    end

    // Overrun: run, then three ticks 10 clocks apart while busy.
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (9) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    repeat (300) step(1'b0, 1'b1, 1'b0);
    check_eq("overrun_cnt_two", 64'(overrun_cnt_o), 64'd2);

    // Freeze channel 1 for one run.
    freeze = 4'b0010;
    step(1'b1, 1'b1, 1'b0);
    repeat (135) step(1'b0, 1'b1, 1'b0);
    freeze = '0;
    step(1'b1, 1'b1, 1'b0);
    repeat (135) step(1'b0, 1'b1, 1'b0);

    // Controller not ready: ticks ignored; drop ready mid-run with a pending tick.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (135) step(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a run.
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (135) step(1'b0, 1'b1, 1'b0);

    // Random traffic: frequent ticks keep runs back to back so pointers wrap.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int c = 0; c < NUM; c++)
          delay[c] = ($urandom_range(0, 7) == 0) ? 6'(RING - 1) : 6'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 7) == 0) freeze = 4'($urandom);
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2999) != 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
